// File: rtl/bram_pkg.sv
// bram_pkg: shared types and helpers for the byte-enable true-dual-port RAM.
package bram_pkg;

    typedef enum logic {
        BRAM_CLEAR = 1'b0,
        BRAM_READY = 1'b1
    } bram_state_e;

    function automatic int nbe(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/bram_tdp_be_if.sv
// bram_tdp_be_if: request/response bundle for both RAM ports plus status.
interface bram_tdp_be_if
    import bram_pkg::*;
#(
    parameter int ADDR_ = 8,
    parameter int DATA_ = 32,
    parameter int BYTE_ = 8
);
    localparam int NBE = nbe(DATA_, BYTE_);

    logic             ready;
    logic             ena;
    logic             enb;
    logic             wea;
    logic             web;
    logic [NBE-1:0]   bea;
    logic [NBE-1:0]   beb;
    logic [ADDR_-1:0] addra;
    logic [ADDR_-1:0] addrb;
    logic [DATA_-1:0] dina;
    logic [DATA_-1:0] dinb;
    logic [DATA_-1:0] douta;
    logic [DATA_-1:0] doutb;
    logic             valida;
    logic             validb;
    logic             collision;

    modport master (
        output ena, enb, wea, web, bea, beb, addra, addrb, dina, dinb,
        input  ready, douta, doutb, valida, validb, collision
    );

    modport slave (
        input  ena, enb, wea, web, bea, beb, addra, addrb, dina, dinb,
        output ready, douta, doutb, valida, validb, collision
    );

endinterface

// File: rtl/bram_clr.sv
// bram_clr: post-reset clear sequencer, zeroes one word per cycle then opens the ports.
module bram_clr
    import bram_pkg::*;
#(
    parameter int ADDR_  = 8,
    parameter int CLEAR_ = 1
) (
    input  logic             clk,
    input  logic             aclr_n,
    output logic             ready_o,
    output logic             clr_we_o,
    output logic [ADDR_-1:0] clr_addr_o
);
    bram_state_e      state_q;
    logic [ADDR_-1:0] cnt_q;
    logic             ready_q;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= (CLEAR_ != 0) ? BRAM_CLEAR : BRAM_READY;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == BRAM_CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) begin
                state_q <= BRAM_READY;
                ready_q <= 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready_o    = ready_q;
    assign clr_we_o   = (state_q == BRAM_CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/bram_tdp_be.sv
// bram_tdp_be: true-dual-port RAM with byte enables, A-priority collisions,
// optional output register and a post-reset clear routed through port A.
module bram_tdp_be
    import bram_pkg::*;
#(
    parameter int ADDR_  = 8,
    parameter int DATA_  = 32,
    parameter int BYTE_  = 8,
    parameter int OREG_  = 0,
    parameter int CLEAR_ = 1
) (
    input  logic          clk,
    input  logic          aclr_n,
    bram_tdp_be_if.slave  bus
);
    localparam int NBE   = nbe(DATA_, BYTE_);
    localparam int DEPTH = 2 ** ADDR_;

    if (DATA_ % BYTE_ != 0) begin : g_bad_width
        $error("DATA_ must be a multiple of BYTE_");
    end

    logic [DATA_-1:0] mem [DEPTH];

    logic             ready;
    logic             clr_we;
    logic [ADDR_-1:0] clr_addr;

    bram_clr #(.ADDR_(ADDR_), .CLEAR_(CLEAR_)) u_clr (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .ready_o    (ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    logic acc_a, acc_b, wr_a, wr_b, col_d;
    assign acc_a = bus.ena & ready;
    assign acc_b = bus.enb & ready;
    assign wr_a  = acc_a & bus.wea;
    assign wr_b  = acc_b & bus.web;
    assign col_d = wr_a & wr_b & (bus.addra == bus.addrb) & (|(bus.bea & bus.beb));

    // Port A write path carries the clear sequencer while the ports are closed.
    logic             wa_en;
    logic [ADDR_-1:0] wa_addr;
    logic [NBE-1:0]   wa_be;
    logic [DATA_-1:0] wa_data;
    assign wa_en   = clr_we | wr_a;
    assign wa_addr = clr_we ? clr_addr : bus.addra;
    assign wa_be   = clr_we ? {NBE{1'b1}} : bus.bea;
    assign wa_data = clr_we ? '0 : bus.dina;

    logic [DATA_-1:0] old_a, old_b, new_a, new_b;
    assign old_a = mem[bus.addra];
    assign old_b = mem[bus.addrb];

    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NBE; i++) begin
            new_a[i*BYTE_ +: BYTE_] = (wr_a & bus.bea[i]) ? bus.dina[i*BYTE_ +: BYTE_] : old_a[i*BYTE_ +: BYTE_];
            new_b[i*BYTE_ +: BYTE_] = (wr_b & bus.beb[i]) ? bus.dinb[i*BYTE_ +: BYTE_] : old_b[i*BYTE_ +: BYTE_];
        end
    end

    // B lanes are written first so an overlapping A lane overrides them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBE; i++) begin
            if (wr_b && bus.beb[i])
                mem[bus.addrb][i*BYTE_ +: BYTE_] <= bus.dinb[i*BYTE_ +: BYTE_];
            if (wa_en && wa_be[i])
                mem[wa_addr][i*BYTE_ +: BYTE_] <= wa_data[i*BYTE_ +: BYTE_];
        end
    end

    logic [DATA_-1:0] dout_a1_q, dout_b1_q;
    logic             val_a1_q, val_b1_q, col_q;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            dout_a1_q <= '0;
            dout_b1_q <= '0;
            val_a1_q  <= 1'b0;
            val_b1_q  <= 1'b0;
            col_q     <= 1'b0;
        end else begin
            dout_a1_q <= acc_a ? new_a : dout_a1_q;
            dout_b1_q <= acc_b ? new_b : dout_b1_q;
            val_a1_q  <= acc_a;
            val_b1_q  <= acc_b;
            col_q     <= col_d;
        end
    end

    assign bus.ready     = ready;
    assign bus.collision = col_q;

    if (OREG_ != 0) begin : g_oreg
        logic [DATA_-1:0] dout_a2_q, dout_b2_q;
        logic             val_a2_q, val_b2_q;
        always_ff @(posedge clk or negedge aclr_n) begin
            if (!aclr_n) begin
                dout_a2_q <= '0;
                dout_b2_q <= '0;
                val_a2_q  <= 1'b0;
                val_b2_q  <= 1'b0;
            end else begin
                dout_a2_q <= val_a1_q ? dout_a1_q : dout_a2_q;
                dout_b2_q <= val_b1_q ? dout_b1_q : dout_b2_q;
                val_a2_q  <= val_a1_q;
                val_b2_q  <= val_b1_q;
            end
        end
        assign bus.douta  = dout_a2_q;
        assign bus.doutb  = dout_b2_q;
        assign bus.valida = val_a2_q;
        assign bus.validb = val_b2_q;
    end else begin : g_noreg
        assign bus.douta  = dout_a1_q;
        assign bus.doutb  = dout_b1_q;
        assign bus.valida = val_a1_q;
        assign bus.validb = val_b1_q;
    end

endmodule

// File: doc/bram_tdp_be.md
# bram_tdp_be

Parametrised true-dual-port block RAM with per-byte write enables, selectable read latency, deterministic write-collision resolution and a built-in clear sequencer. It is the general-purpose successor to the fixed-width dual-port RAM. It serves as shared scratch/register storage between two MARVIN pipeline agents on one clock domain. The memory array is inferred, so the block is vendor-neutral.

## Interface
- ADDR_, 8, address width; depth = 2**ADDR_ words
- DATA_, 32, word width; must be a multiple of BYTE_
- BYTE_, 8, byte-lane width; NBE = DATA_/BYTE_ lanes
- OREG_, 0, 0: read latency 1; 1: extra output register, read latency 2
- CLEAR_, 1, 1: zero the whole array after every reset; 0: no clear

Ports:
- clk  in  1  single clock, rising edge
- aclr_n  in  1  asynchronous active-low reset
- ready  out  1  high when ports accept requests
- ena, enb  in  1  port request strobe (read, or write when we*)
- wea, web  in  1  write enable, qualified by en*
- bea, beb  in  NBE  byte-lane enables for writes
- addra, addrb  in  ADDR_  word address
- dina, dinb  in  DATA_  write data
- douta, doutb  out  DATA_  read data
- valida, validb  out  1  douta/doutb valid strobe
- collision  out  1  one-cycle pulse: same-address overlapping-lane double write

## Operation
- Reset values: douta=doutb=0, valida=validb=0, ready=0, collision=0, clear counter=0. Array contents are not touched by aclr_n itself.
- FSM states:
  - CLEAR: counter writes 0 to word[cnt], one word per cycle. ready=0. Port requests are dropped: no write, no valid.
  - READY: ready=1.
- Transitions:
  - Reset → CLEAR if CLEAR_=1, else READY.
  - CLEAR → READY after word 2**ADDR_-1 is written.
  - READY has no exit except reset.
- Accepted request: en*&ready. Every accepted request, read or write, produces a read of addr* and a valid* pulse.
- Write: lanes with be*[i]=1 take din*[i]; other lanes keep their old value.
- Same-port read-during-write: dout returns new data merged per lane (written lanes new, unwritten lanes old).
- Mixed-port read-during-write: reader gets OLD word.
- Double write, same address, same cycle:
  - Lanes enabled by both ports: port A wins.
  - Lanes enabled by one port only: that port writes.
  - collision pulses if any lane overlaps.
  - Different addresses never collide.
- Reset mid-CLEAR: counter restarts at 0; the full clear is repeated.

## Timing
- Read latency L = 1+OREG_ cycles from the accepting edge to dout/valid. Throughput is 1 request per port per cycle.
- dout holds its last value when valid=0.
- collision is registered and asserts 1 cycle after the offending edge.
- CLEAR duration: ready rises exactly 2**ADDR_ edges after the first edge with aclr_n high.
- aclr_n assertion clears all outputs immediately, without waiting for a clock edge.

## Structure
- Package bram_pkg:
  - bram_state_e {BRAM_CLEAR, BRAM_READY}
  - function nbe(DATA_, BYTE_)
  - elaboration assertion DATA_%BYTE_==0.
- Sub-module bram_clr: clear sequencer (FSM + counter). Outputs ready, clr_we, clr_addr. Top muxes the clear write onto port A.
- Top holds the array, lane-merge/priority logic, optional output register and valid pipeline.

## Test plan
All scenarios: ADDR_=4, DATA_=32, BYTE_=8.
- Release aclr_n, CLEAR_=1 → ready low 16 cycles, then high. Read all 16 addresses → all 0x00000000.
- A writes addr 3 0xDEADBEEF be=1111; next cycle A writes addr 3 0x11223344 be=0101 → same-cycle douta=0xDE22BE44, valida 1 cycle later (OREG_=0). Repeat with OREG_=1 → latency 2.
- Same edge: A writes addr 5 0xAAAAAAAA be=0011, B writes addr 5 0xBBBBBBBB be=0110 → word[5]=0x00BBAAAA, collision=1 on the next cycle. A addr 5 / B addr 6 → collision stays 0.
- A writes addr 7 0x12345678 while B reads addr 7 → doutb=0x00000000. B reads addr 7 next cycle → 0x12345678.
- B writes addr 2 0xFFFFFFFF during CLEAR → no validb. After ready, read addr 2 → 0x00000000.
- Assert aclr_n at clear count 9 → all outputs 0 asynchronously. After release, ready rises only after a further 16 cycles.
